ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter and sequencer for the shared 32x1024 single-port data RAM. It accepts read/write commands from the instruction-fetch port (m0) and the load/store port (m1), picks one per cycle round-robin, and drives the RAM's cs/read_en/write_en/addr/data_in strobes. It returns read data with a fixed two-cycle latency, and sustains one access per cycle. It forwards the most recent write to cover the RAM's address-sensitive read path.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, RAM word width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mX_req  in  1  request valid, X = 0 or 1; held until granted
- mX_we  in  1  1 means write, 0 means read
- mX_addr  in  ADDR_W  word address
- mX_wdata  in  DATA_W  write data
- mX_gnt  out  1  combinational accept pulse; the command is taken at this edge
- mX_done  out  1  one-cycle completion pulse for both reads and writes
- mX_rdata  out  DATA_W  read data, valid while mX_done is high after a read
- ram_cs, ram_read_en, ram_write_en  out  1  RAM strobes
- ram_addr  out  ADDR_W
- ram_wdata  out  DATA_W
- ram_rdata  in  DATA_W  RAM data_out; tri-stated unless read_en and cs

## Operation
- Arbitration:
  - Requests are granted only when rst=0.
  - If exactly one mX_req is high, that requester is granted.
  - If both are high, the requester not granted last is granted.
  - The `last` pointer updates on every grant and resets to 1, so m0 wins the first tie.
- Pipeline:
  - Stage A (grant): latch {owner, we, addr, wdata} into the command register and set `busy`.
  - Stage B (access): drive the RAM from the command register.
  - Stage C (respond): pulse done to the owner.
- A new grant is allowed in every cycle, including a cycle in which stage B is active. No back-pressure exists beyond the req/gnt handshake.
- Access cycle, write: ram_cs=1, ram_write_en=1, ram_read_en=0. The RAM commits at the closing edge.
- Access cycle, read: ram_cs=1, ram_read_en=1, ram_write_en=0. ram_rdata is sampled into the response register at the closing edge.
- ram_read_en and ram_write_en are never high together.
- Idle (no stage B command): cs, read_en and write_en are all 0; ram_addr and ram_wdata hold their last values.
- Write forwarding:
  - The block keeps a register {fwd_valid, fwd_addr, fwd_data}, loaded on every stage-B write.
  - A stage-B read with addr == fwd_addr and fwd_valid=1 returns fwd_data instead of ram_rdata.
  - Reason: the RAM's read data updates only on an address change, so a read of a just-written, unchanged address would otherwise return stale data.
- mX_rdata holds its value between done pulses. It is undefined after write completions; the bench ignores it then.

## Timing
- Request granted in cycle N → RAM strobes in cycle N+1 → mX_done high in cycle N+2 (reads also present mX_rdata). Latency is 2 and throughput is 1 per cycle.
- A requester keeping req high after its grant is re-arbitrated in cycle N+1. It may win again only if the other requester is idle.
- Back-to-back write then read to the same address, granted in cycles N and N+1: the read returns the written data in N+3 via forwarding.
- Reset values: gnt=0, done=0, rdata=0, ram_cs/read_en/write_en=0, ram_addr=0, ram_wdata=0, busy=0, fwd_valid=0, last=1.
- Reset mid-operation:
  - RAM strobes are gated with ~rst, so no write commits in any cycle where rst=1.
  - In-flight commands are dropped and their done never pulses.
  - No gnt is issued while rst=1.
- Simultaneous events: a read and a write to the same address in consecutive pipeline slots are handled by forwarding. Same-cycle access conflicts cannot occur because only one command occupies stage B.

## Structure
- Package nova_mem_pkg holds:
  - ADDR_W and DATA_W constants
  - the requester-ID enum (REQ_FETCH=0, REQ_LSU=1)
  - the command struct {owner, we, addr, wdata}
- Sub-module rr_arbiter_2: a combinational two-way round-robin picker, plus the registered `last` pointer, with inputs req[1:0] and output gnt[1:0].
- The top level holds the command register, response register, forwarding register and strobe gating.

## Test plan
- Single read: preload mem[5]=0xDEADBEEF; m0 read addr 5 granted at N → ram_read_en=1 and ram_addr=5 at N+1; m0_done=1 with m0_rdata=0xDEADBEEF at N+2.
- Tie: m0 and m1 both hold req at reset exit → grants alternate m0, m1, m0, m1 on consecutive cycles; each done follows its grant by 2 cycles.
- Forwarding: m1 write 0x12345678 to addr 9, then m1 read addr 9 granted the next cycle → m1_rdata=0x12345678 (not stale) two cycles after the read grant.
- Streaming: m1 performs 4 writes to addrs 0–3, then 4 reads → one grant per cycle, reads return the written data, and ram_read_en and ram_write_en are never high together.
- Reset mid-write: assert rst in the stage-B cycle of a write of 0xAAAA5555 to addr 7 → ram_write_en=0 in that cycle, mem[7] unchanged, no done pulse, all outputs zero the next cycle.
- Idle: no requests for 10 cycles → ram_cs=0 throughout, and ram_addr holds its last value.

Source files
------------

// File: rtl/nova_mem_pkg.sv
// nova_mem_pkg: shared definitions for the data-RAM arbiter.
//   ADDR_W / DATA_W : RAM word-address and word widths
//   req_id_e        : requester identity (fetch port, load/store port)
//   mem_cmd_t       : one accepted command as carried down the pipeline
package nova_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LSU   = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e             owner;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin picker.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request vector (already qualified by the caller)
//   gnt[1:0] : one-hot combinational grant
// The registered `last` pointer remembers who won most recently; on a tie
// the other requester is chosen. It resets to 1 so requester 0 wins the
// first tie.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates fetch (m0) and load/store (m1) commands onto the
// shared single-port data RAM with a fixed two-cycle latency.
//   clk, rst              : clock, synchronous active-high reset
//   mX_req/we/addr/wdata  : command inputs, held until mX_gnt
//   mX_gnt                : combinational accept
//   mX_done, mX_rdata     : completion pulse and read data (two cycles after gnt)
//   ram_cs/read_en/write_en, ram_addr, ram_wdata : RAM strobes and buses
//   ram_rdata             : RAM data out
// Pipeline: grant -> access (command register drives RAM) -> respond.
module ram_arbiter
  import nova_mem_pkg::*;
#(
  parameter int ADDR_W = nova_mem_pkg::ADDR_W,
  parameter int DATA_W = nova_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_cs,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0]        req_v;
  logic [1:0]        gnt_v;

  logic              busy_q, busy_d;
  mem_cmd_t          cmd_q, cmd_d;

  logic              rsp_valid_q, rsp_valid_d;
  req_id_e           rsp_owner_q, rsp_owner_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              access;
  logic              fwd_hit;
  logic [DATA_W-1:0] rd_word;

  // No grant may be issued while reset is asserted.
  assign req_v = {m1_req, m0_req} & {2{~rst}};

  rr_arbiter_2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req_v),
    .gnt (gnt_v)
  );

  assign m0_gnt = gnt_v[0];
  assign m1_gnt = gnt_v[1];

  // Stage A: capture the winner. The command register holds when idle so
  // ram_addr/ram_wdata keep their last values.
  always_comb begin
    busy_d = |gnt_v;
    cmd_d  = cmd_q;
    if (gnt_v[1]) begin
      cmd_d.owner = REQ_LSU;
      cmd_d.we    = m1_we;
      cmd_d.addr  = m1_addr;
      cmd_d.wdata = m1_wdata;
    end else if (gnt_v[0]) begin
      cmd_d.owner = REQ_FETCH;
      cmd_d.we    = m0_we;
      cmd_d.addr  = m0_addr;
      cmd_d.wdata = m0_wdata;
    end
  end

  // Stage B: strobes gated with ~rst so nothing commits during reset.
  assign access       = busy_q & ~rst;
  assign ram_cs       = access;
  assign ram_write_en = access & cmd_q.we;
  assign ram_read_en  = access & ~cmd_q.we;
  assign ram_addr     = cmd_q.addr;
  assign ram_wdata    = cmd_q.wdata;

  // The RAM only refreshes its output on an address change, so a read of
  // the most recently written address is served from the forward register.
  assign fwd_hit = fwd_valid_q && (fwd_addr_q == cmd_q.addr);
  assign rd_word = fwd_hit ? fwd_data_q : ram_rdata;

  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    if (ram_write_en) begin
      fwd_valid_d = 1'b1;
      fwd_addr_d  = cmd_q.addr;
      fwd_data_d  = cmd_q.wdata;
    end
  end

  // Stage C: response register; each requester keeps its own read data so
  // it is stable between that requester's done pulses.
  always_comb begin
    rsp_valid_d = access;
    rsp_owner_d = cmd_q.owner;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (ram_read_en) begin
      if (cmd_q.owner == REQ_LSU) begin
        rdata1_d = rd_word;
      end else begin
        rdata0_d = rd_word;
      end
    end
  end

  assign m0_done  = rsp_valid_q & ~rst & (rsp_owner_q == REQ_FETCH);
  assign m1_done  = rsp_valid_q & ~rst & (rsp_owner_q == REQ_LSU);
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= REQ_FETCH;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against an
// in-order memory reference model (grant rules + two-slot delay line).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_cs, ram_read_en, ram_write_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .ram_cs(ram_cs), .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: output refreshes only on an address change (or after preload).
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic        pre_done = 1'b0;
  logic [31:0] ram_mem [0:1023];
  logic [31:0] ram_dout;

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (ram_cs && ram_write_en) ram_mem[ram_addr] <= ram_wdata;
  end
  always @(ram_addr or pre_done) ram_dout = ram_mem[ram_addr];
  assign ram_rdata = (ram_cs && ram_read_en) ? ram_dout : 32'h0;

  // Reference model
  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        valid;
    logic        owner;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } slot_t;

  cmd_t        q0[$];
  cmd_t        q1[$];
  logic [31:0] ref_mem [0:15];
  slot_t       s1 = '0, s2 = '0;
  logic        mlast = 1'b1;
  logic [9:0]  hold_addr = '0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [9:0] addr, input logic [31:0] d);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = d;
    return c;
  endfunction

  task automatic step(input logic r);
    logic  g0, g1, exp_cs;
    logic [9:0] exp_addr;
    slot_t nw;
    @(posedge clk); #1;
    rst    = r;
    m0_req = (q0.size() != 0);
    if (m0_req) begin m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; end
    m1_req = (q1.size() != 0);
    if (m1_req) begin m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; end
    @(negedge clk);
    g0 = 1'b0; g1 = 1'b0;
    if (!r) begin
      if (m0_req && m1_req) begin g0 = mlast; g1 = !mlast; end
      else begin g0 = m0_req; g1 = m1_req; end
    end
    chk("gnt0", m0_gnt, g0);
    chk("gnt1", m1_gnt, g1);
    exp_cs = s1.valid && !r;
    chk("ram_cs", ram_cs, exp_cs);
    chk("ram_write_en", ram_write_en, exp_cs && s1.we);
    chk("ram_read_en", ram_read_en, exp_cs && !s1.we);
    chk("rw_excl", ram_read_en & ram_write_en, 1'b0);
    exp_addr = s1.valid ? s1.addr : hold_addr;
    chk("ram_addr", ram_addr, exp_addr);
    if (exp_cs && s1.we) chk("ram_wdata", ram_wdata, s1.wdata);
    chk("done0", m0_done, s2.valid && !r && !s2.owner);
    chk("done1", m1_done, s2.valid && !r && s2.owner);
    if (s2.valid && !r && !s2.we) begin
      if (s2.owner) chk("rdata1", m1_rdata, s2.data);
      else          chk("rdata0", m0_rdata, s2.data);
    end
    if (r) begin
      s1 = '0; s2 = '0; mlast = 1'b1; hold_addr = '0;
    end else begin
      if (s1.valid) begin
        hold_addr = s1.addr;
        if (s1.we) ref_mem[s1.addr[3:0]] = s1.wdata;
        else       s1.data = ref_mem[s1.addr[3:0]];
      end
      s2 = s1;
      nw = '0;
      if (g0) begin
        nw = {1'b1, 1'b0, q0[0].we, q0[0].addr, q0[0].wdata, 32'h0};
        void'(q0.pop_front());
        mlast = 1'b0;
      end else if (g1) begin
        nw = {1'b1, 1'b1, q1[0].we, q1[0].addr, q1[0].wdata, 32'h0};
        void'(q1.pop_front());
        mlast = 1'b1;
      end
      s1 = nw;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      step(1'b0);
    end
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    // Preload addresses 0..15 while held in reset; all random traffic stays there.
    for (int i = 0; i < 16; i++) begin
      pre_we   = 1'b1;
      pre_addr = 10'(i);
      pre_data = (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h07070707 : $urandom;
      ref_mem[i] = pre_data;
      step(1'b1);
    end
    pre_we   = 1'b0;
    pre_done = 1'b1;
    step(1'b1);

    // Reset state
    step(1'b0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);

    // Tie at reset exit: m0, m1, m0, m1 ...
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, 10'(i), 32'h0));
      q1.push_back(mk(1'b0, 10'(i + 10), 32'h0));
    end
    drain();

    // Single read of preloaded word
    q0.push_back(mk(1'b0, 10'd5, 32'h0));
    drain();
    chk("single_read", m0_rdata, 32'hDEADBEEF);

    // Write then read same address on consecutive grants
    q1.push_back(mk(1'b1, 10'd9, 32'h12345678));
    q1.push_back(mk(1'b0, 10'd9, 32'h0));
    drain();
    chk("fwd_read", m1_rdata, 32'h12345678);

    // Streaming writes then reads
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, 10'(i), 32'hC0DE0000 + 32'(i)));
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 10'(i), 32'h0));
    drain();
    chk("stream_last", m1_rdata, 32'hC0DE0003);

    // Reset during the access cycle of a write
    q1.push_back(mk(1'b1, 10'd7, 32'hAAAA5555));
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("post_rst_wdata", ram_wdata, 32'h0);
    chk("post_rst_rdata0", m0_rdata, 32'h0);
    chk("post_rst_rdata1", m1_rdata, 32'h0);
    q0.push_back(mk(1'b0, 10'd7, 32'h0));
    drain();
    chk("mem7_kept", m0_rdata, 32'h07070707);

    // Idle
    for (int i = 0; i < 10; i++) step(1'b0);

    // Randomized traffic on a small address window to exercise forwarding
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) != 0)
        q0.push_back(mk(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom));
      if (q1.size() == 0 && $urandom_range(0, 2) != 0)
        q1.push_back(mk(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom));
      step(1'b0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
